stream_checker: RTL and testbench

//   Synthesizable scoreboard for CRC/MAC streams. Replaces hand-called per-word assert tasks.
//   The bench pushes expected words into an internal FIFO. Each word the DUT delivers is

---
 rtl/stream_checker.sv | 200 ++++++++++++++++++++
 tb/tb_stream_checker.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_checker.sv
// -----------------------------------------------------------------------------
// stream_checker
//
// Purpose:
//   In-order scoreboard for one checked stream. Expected words are queued in a
//   small FIFO; every actual word from the device under test is compared with
//   the FIFO head. Saturating pass/fail counters are kept, and the first failure
//   is captured so it can be inspected after a run.
//
// Parameters:
//   DATA_WIDTH   width of expected and actual words
//   DEPTH        expected-word FIFO entries (power of 2, >= 2)
//   COUNT_WIDTH  width of pass/fail/index counters
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   clear        synchronous clear of FIFO, counters and flags
//   exp_data     expected word
//   exp_valid    expected word offered
//   exp_ready    FIFO not full; a push happens when exp_valid & exp_ready
//   act_data     actual word from the device under test
//   act_valid    actual word present; always accepted
//   cmp_mask     compare mask, 0 bits are don't-care (STREAM_CHECKER_MASK_EN only)
//   pass_count   matched words, saturating
//   fail_count   mismatched words plus underflows, saturating
//   mismatch     one-cycle pulse after a failed compare or underflow
//   underflow    sticky: an actual word arrived while the FIFO was empty
//   first_valid  sticky: a first failure has been captured
//   first_exp    expected word of the first failure (0 for an underflow)
//   first_act    actual word of the first failure
//   first_index  index (from 0) of the actual word that first failed
//   level        number of words held in the FIFO
//
// Configuration macro:
//   STREAM_CHECKER_MASK_EN  adds the cmp_mask port and a masked compare.
//   When undefined the compare is an exact full-width compare.
// -----------------------------------------------------------------------------
module stream_checker #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic [DATA_WIDTH-1:0]    exp_data,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [DATA_WIDTH-1:0]    act_data,
  input  logic                     act_valid,
`ifdef STREAM_CHECKER_MASK_EN
  input  logic [DATA_WIDTH-1:0]    cmp_mask,
`endif
  output logic [COUNT_WIDTH-1:0]   pass_count,
  output logic [COUNT_WIDTH-1:0]   fail_count,
  output logic                     mismatch,
  output logic                     underflow,
  output logic                     first_valid,
  output logic [DATA_WIDTH-1:0]    first_exp,
  output logic [DATA_WIDTH-1:0]    first_act,
  output logic [COUNT_WIDTH-1:0]   first_index,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [AW:0]            r_wrPtr;
  logic [AW:0]            r_rdPtr;
  logic [COUNT_WIDTH-1:0] r_passCount;
  logic [COUNT_WIDTH-1:0] r_failCount;
  logic [COUNT_WIDTH-1:0] r_actIndex;
  logic                   r_mismatch;
  logic                   r_underflow;
  logic                   r_firstValid;
  logic [DATA_WIDTH-1:0]  r_firstExp;
  logic [DATA_WIDTH-1:0]  r_firstAct;
  logic [COUNT_WIDTH-1:0] r_firstIndex;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_match;
  logic                   w_hit;
  logic                   w_fail;
  logic [DATA_WIDTH-1:0]  w_head;
  logic [DATA_WIDTH-1:0]  w_cmpMask;

  // Pointers carry one extra wrap bit so that full and empty can be told
  // apart when the low address bits are equal.
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_head  = r_mem[r_rdPtr[AW-1:0]];

`ifdef STREAM_CHECKER_MASK_EN
  assign w_cmpMask = cmp_mask;
`else
  assign w_cmpMask = '1;
`endif

  // A push is refused while full even if a pop happens in the same cycle;
  // an actual word never pops an empty FIFO, so there is no bypass path.
  assign w_push  = exp_valid && !w_full;
  assign w_pop   = act_valid && !w_empty;
  assign w_match = (((w_head ^ act_data) & w_cmpMask) == '0);
  assign w_hit   = act_valid && !w_empty && w_match;
  assign w_fail  = act_valid && (w_empty || !w_match);

  // Storage array for queued expected words; it needs no reset because the
  // pointers alone decide which entries are meaningful.
  always_ff @(posedge clock) begin
    if (w_push && !clear) begin
      r_mem[r_wrPtr[AW-1:0]] <= exp_data;
    end
  end

  // FIFO pointers; clear discards everything queued and wins over any push
  // or pop offered in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  // Saturating result counters plus the free-running actual-word index.
  // The index wraps naturally; the result counters stick at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_passCount <= '0;
      r_failCount <= '0;
      r_actIndex  <= '0;
    end else if (clear) begin
      r_passCount <= '0;
      r_failCount <= '0;
      r_actIndex  <= '0;
    end else begin
      if (w_hit && !(&r_passCount))  r_passCount <= r_passCount + COUNT_WIDTH'(1);
      if (w_fail && !(&r_failCount)) r_failCount <= r_failCount + COUNT_WIDTH'(1);
      if (act_valid)                 r_actIndex  <= r_actIndex + COUNT_WIDTH'(1);
    end
  end

  // Status flags: mismatch pulses for the cycle after any failure, while
  // underflow stays set until reset or clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mismatch  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_mismatch  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_mismatch <= w_fail;
      if (act_valid && w_empty) r_underflow <= 1'b1;
    end
  end

  // First-failure capture. Only the earliest failure is recorded; the words
  // are kept unmasked so the full difference can be inspected afterwards.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_firstValid <= 1'b0;
      r_firstExp   <= '0;
      r_firstAct   <= '0;
      r_firstIndex <= '0;
    end else if (clear) begin
      r_firstValid <= 1'b0;
      r_firstExp   <= '0;
      r_firstAct   <= '0;
      r_firstIndex <= '0;
    end else if (w_fail && !r_firstValid) begin
      r_firstValid <= 1'b1;
      r_firstExp   <= w_empty ? '0 : w_head;
      r_firstAct   <= act_data;
      r_firstIndex <= r_actIndex;
    end
  end

  assign exp_ready   = !w_full;
  assign level       = r_wrPtr - r_rdPtr;
  assign pass_count  = r_passCount;
  assign fail_count  = r_failCount;
  assign mismatch    = r_mismatch;
  assign underflow   = r_underflow;
  assign first_valid = r_firstValid;
  assign first_exp   = r_firstExp;
  assign first_act   = r_firstAct;
  assign first_index = r_firstIndex;

endmodule

// File: tb/tb_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_stream_checker
//
// Self-checking bench for stream_checker. The main instance (DATA_WIDTH=8,
// DEPTH=4, COUNT_WIDTH=8) is followed by a queue-based reference model; a
// second instance with COUNT_WIDTH=2 exercises counter saturation.
// Mask scenario only exists when STREAM_CHECKER_MASK_EN is defined.
// -----------------------------------------------------------------------------
module tb_stream_checker;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       exp_valid;
  logic       act_valid;
  logic [7:0] exp_data;
  logic [7:0] act_data;
  logic [7:0] cmpMask;

  logic       exp_ready;
  logic [7:0] pass_count;
  logic [7:0] fail_count;
  logic       mismatch;
  logic       underflow;
  logic       first_valid;
  logic [7:0] first_exp;
  logic [7:0] first_act;
  logic [7:0] first_index;
  logic [2:0] level;

  logic       sClear;
  logic       sExpValid;
  logic       sActValid;
  logic [7:0] sExpData;
  logic [7:0] sActData;
  logic       sExpReady;
  logic [1:0] sPass;
  logic [1:0] sFail;
  logic       sMismatch;
  logic       sUnderflow;
  logic       sFirstValid;
  logic [7:0] sFirstExp;
  logic [7:0] sFirstAct;
  logic [1:0] sFirstIndex;
  logic [2:0] sLevel;

  // Reference model state
  logic [7:0] mQ[$];
  int         mPass;
  int         mFail;
  bit         mMismatch;
  bit         mUnder;
  bit         mFirstValid;
  logic [7:0] mFirstExp;
  logic [7:0] mFirstAct;
  logic [7:0] mFirstIdx;
  logic [7:0] mIdx;

  int errors = 0;
  int checks = 0;

  // Free-running clock, 10 time units per period
  always #5 clock = ~clock;

  stream_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .COUNT_WIDTH(CW)) u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (clear),
    .exp_data    (exp_data),
    .exp_valid   (exp_valid),
    .exp_ready   (exp_ready),
    .act_data    (act_data),
    .act_valid   (act_valid),
`ifdef STREAM_CHECKER_MASK_EN
    .cmp_mask    (cmpMask),
`endif
    .pass_count  (pass_count),
    .fail_count  (fail_count),
    .mismatch    (mismatch),
    .underflow   (underflow),
    .first_valid (first_valid),
    .first_exp   (first_exp),
    .first_act   (first_act),
    .first_index (first_index),
    .level       (level)
  );

  stream_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .COUNT_WIDTH(2)) u_sat (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (sClear),
    .exp_data    (sExpData),
    .exp_valid   (sExpValid),
    .exp_ready   (sExpReady),
    .act_data    (sActData),
    .act_valid   (sActValid),
`ifdef STREAM_CHECKER_MASK_EN
    .cmp_mask    (8'hFF),
`endif
    .pass_count  (sPass),
    .fail_count  (sFail),
    .mismatch    (sMismatch),
    .underflow   (sUnderflow),
    .first_valid (sFirstValid),
    .first_exp   (sFirstExp),
    .first_act   (sFirstAct),
    .first_index (sFirstIndex),
    .level       (sLevel)
  );

  // Single comparison point; every check in the bench goes through here
  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mPass       = 0;
    mFail       = 0;
    mMismatch   = 1'b0;
    mUnder      = 1'b0;
    mFirstValid = 1'b0;
    mFirstExp   = 8'h00;
    mFirstAct   = 8'h00;
    mFirstIdx   = 8'h00;
    mIdx        = 8'h00;
  endtask

  // Advance the model by one clock edge using pre-edge occupancy
  task automatic modelStep(input bit push, input logic [7:0] pd, input bit act,
                           input logic [7:0] ad, input bit clr, input logic [7:0] mask);
    bit         wasFull;
    bit         fail;
    logic [7:0] head;
    logic [7:0] failExp;
    if (clr) begin
      modelReset();
    end else begin
      wasFull = (mQ.size() == DEPTH);
      fail    = 1'b0;
      failExp = 8'h00;
      if (act) begin
        if (mQ.size() > 0) begin
          head = mQ.pop_front();
          if (((head ^ ad) & mask) == 8'h00) begin
            if (mPass < 255) mPass++;
          end else begin
            fail    = 1'b1;
            failExp = head;
          end
        end else begin
          fail   = 1'b1;
          mUnder = 1'b1;
        end
      end
      if (fail) begin
        if (mFail < 255) mFail++;
        if (!mFirstValid) begin
          mFirstValid = 1'b1;
          mFirstExp   = failExp;
          mFirstAct   = ad;
          mFirstIdx   = mIdx;
        end
      end
      if (act) mIdx = mIdx + 8'd1;
      mMismatch = fail;
      if (push && !wasFull) mQ.push_back(pd);
    end
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, ".pass"},       pass_count,  mPass);
    compare({tag, ".fail"},       fail_count,  mFail);
    compare({tag, ".mismatch"},   mismatch,    mMismatch);
    compare({tag, ".underflow"},  underflow,   mUnder);
    compare({tag, ".firstValid"}, first_valid, mFirstValid);
    compare({tag, ".firstExp"},   first_exp,   mFirstExp);
    compare({tag, ".firstAct"},   first_act,   mFirstAct);
    compare({tag, ".firstIndex"}, first_index, mFirstIdx);
    compare({tag, ".level"},      level,       mQ.size());
    compare({tag, ".expReady"},   exp_ready,   (mQ.size() < DEPTH));
  endtask

  // One clock of stimulus on the main instance, then a model step and check
  task automatic applyStimulus(input bit push, input logic [7:0] pd, input bit act,
                               input logic [7:0] ad, input bit clr, input string tag);
    @(negedge clock);
    exp_valid = push;
    exp_data  = pd;
    act_valid = act;
    act_data  = ad;
    clear     = clr;
    @(posedge clock);
    modelStep(push, pd, act, ad, clr, cmpMask);
    #1;
    checkOutput(tag);
    exp_valid = 1'b0;
    act_valid = 1'b0;
    clear     = 1'b0;
  endtask

  // One clock of stimulus on the saturation instance
  task automatic applySmall(input bit push, input logic [7:0] pd, input bit act,
                            input logic [7:0] ad, input bit clr);
    @(negedge clock);
    sExpValid = push;
    sExpData  = pd;
    sActValid = act;
    sActData  = ad;
    sClear    = clr;
    @(posedge clock);
    #1;
    sExpValid = 1'b0;
    sActValid = 1'b0;
    sClear    = 1'b0;
  endtask

  // Directed scenarios followed by a randomised run against the model
  initial begin
    bit         rPush;
    bit         rAct;
    logic [7:0] rPd;
    logic [7:0] rAd;

    reset_n   = 1'b0;
    clear     = 1'b0;
    exp_valid = 1'b0;
    act_valid = 1'b0;
    exp_data  = 8'h00;
    act_data  = 8'h00;
    cmpMask   = 8'hFF;
    sClear    = 1'b0;
    sExpValid = 1'b0;
    sActValid = 1'b0;
    sExpData  = 8'h00;
    sActData  = 8'h00;
    modelReset();

    #12;
    checkOutput("reset");
    compare("reset.expReadyConst", exp_ready, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] match scenario");
    applyStimulus(1, 8'hA5, 0, 8'h00, 0, "match.push0");
    applyStimulus(1, 8'h3C, 0, 8'h00, 0, "match.push1");
    applyStimulus(0, 8'h00, 1, 8'hA5, 0, "match.act0");
    applyStimulus(0, 8'h00, 1, 8'h3C, 0, "match.act1");
    compare("match.passConst",  pass_count, 8'd2);
    compare("match.failConst",  fail_count, 8'd0);
    compare("match.levelConst", level,      3'd0);

    $display("[TB] mismatch capture scenario");
    applyStimulus(0, 8'h00, 0, 8'h00, 1, "mis.clear");
    applyStimulus(1, 8'h11, 0, 8'h00, 0, "mis.push0");
    applyStimulus(1, 8'h22, 0, 8'h00, 0, "mis.push1");
    applyStimulus(1, 8'h33, 0, 8'h00, 0, "mis.push2");
    applyStimulus(0, 8'h00, 1, 8'h11, 0, "mis.act0");
    applyStimulus(0, 8'h00, 1, 8'h20, 0, "mis.act1");
    compare("mis.pulse1", mismatch, 1'b1);
    applyStimulus(0, 8'h00, 1, 8'h34, 0, "mis.act2");
    compare("mis.pulse2", mismatch, 1'b1);
    applyStimulus(0, 8'h00, 0, 8'h00, 0, "mis.idle");
    compare("mis.pulseEnd",      mismatch,    1'b0);
    compare("mis.passConst",     pass_count,  8'd1);
    compare("mis.failConst",     fail_count,  8'd2);
    compare("mis.firstExpConst", first_exp,   8'h22);
    compare("mis.firstActConst", first_act,   8'h20);
    compare("mis.firstIdxConst", first_index, 8'd1);

    $display("[TB] full and backpressure scenario");
    applyStimulus(0, 8'h00, 0, 8'h00, 1, "full.clear");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 8'(i), 0, 8'h00, 0, "full.push");
    end
    compare("full.readyConst", exp_ready, 1'b0);
    compare("full.levelConst", level,     3'd4);
    applyStimulus(1, 8'h06, 1, 8'h01, 0, "full.pushPop");
    compare("full.pushPopLevel", level, 3'd3);
    applyStimulus(0, 8'h00, 1, 8'h02, 0, "full.drain2");
    applyStimulus(0, 8'h00, 1, 8'h03, 0, "full.drain3");
    applyStimulus(0, 8'h00, 1, 8'h04, 0, "full.drain4");
    compare("full.passConst", pass_count, 8'd4);
    compare("full.failConst", fail_count, 8'd0);

    $display("[TB] underflow scenario");
    applyStimulus(0, 8'h00, 0, 8'h00, 1, "under.clear");
    applyStimulus(0, 8'h00, 1, 8'h7E, 0, "under.act");
    compare("under.failConst",     fail_count, 8'd1);
    compare("under.flagConst",     underflow,  1'b1);
    compare("under.firstExpConst", first_exp,  8'h00);
    compare("under.firstActConst", first_act,  8'h7E);
    applyStimulus(1, 8'h55, 1, 8'h66, 0, "under.pushAct");
    compare("under.fail2Const", fail_count, 8'd2);
    compare("under.levelConst", level,      3'd1);

    $display("[TB] clear overriding traffic");
    applyStimulus(1, 8'h77, 1, 8'h55, 1, "clr.override");
    compare("clr.passConst",  pass_count, 8'd0);
    compare("clr.failConst",  fail_count, 8'd0);
    compare("clr.levelConst", level,      3'd0);
    compare("clr.underConst", underflow,  1'b0);

`ifdef STREAM_CHECKER_MASK_EN
    $display("[TB] mask scenario");
    cmpMask = 8'hF0;
    applyStimulus(1, 8'hAB, 0, 8'h00, 0, "mask.push0");
    applyStimulus(0, 8'h00, 1, 8'hA4, 0, "mask.act0");
    applyStimulus(1, 8'hAB, 0, 8'h00, 0, "mask.push1");
    applyStimulus(0, 8'h00, 1, 8'hB4, 0, "mask.act1");
    compare("mask.passConst",     pass_count, 8'd1);
    compare("mask.failConst",     fail_count, 8'd1);
    compare("mask.firstExpConst", first_exp,  8'hAB);
    compare("mask.firstActConst", first_act,  8'hB4);
    cmpMask = 8'hFF;
    applyStimulus(0, 8'h00, 0, 8'h00, 1, "mask.clear");
`endif

    $display("[TB] randomised traffic");
    for (int i = 0; i < 60; i++) begin
      rPush = 1'($urandom_range(0, 1));
      rAct  = 1'($urandom_range(0, 1));
      rPd   = 8'($urandom_range(0, 255));
      rAd   = 8'($urandom_range(0, 255));
      if (mQ.size() > 0 && $urandom_range(0, 3) != 0) rAd = mQ[0];
      applyStimulus(rPush, rPd, rAct, rAd, 0, "rand");
    end

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1, 8'h9A, 0, 8'h00, 0, "arst.push");
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("arst.async");
    compare("arst.levelConst", level, 3'd0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1, 8'hC3, 0, 8'h00, 0, "arst.push2");
    applyStimulus(0, 8'h00, 1, 8'hC3, 0, "arst.act");
    compare("arst.passConst", pass_count, 8'd1);
    compare("arst.failConst", fail_count, 8'd0);

    $display("[TB] saturation on narrow counters");
    for (int i = 0; i < 5; i++) begin
      applySmall(1, 8'(8'h40 + i), 0, 8'h00, 0);
      applySmall(0, 8'h00, 1, 8'(8'h40 + i), 0);
    end
    compare("sat.pass", sPass, 2'd3);
    compare("sat.fail", sFail, 2'd0);
    applySmall(1, 8'h99, 1, 8'h12, 1);
    compare("sat.clrPass",  sPass,      2'd0);
    compare("sat.clrFail",  sFail,      2'd0);
    compare("sat.clrLevel", sLevel,     3'd0);
    compare("sat.clrUnder", sUnderflow, 1'b0);
    compare("sat.clrMis",   sMismatch,  1'b0);
    for (int i = 0; i < 5; i++) begin
      applySmall(0, 8'h00, 1, 8'h01, 0);
    end
    compare("sat.failSat",    sFail,       2'd3);
    compare("sat.under",      sUnderflow,  1'b1);
    compare("sat.firstIndex", sFirstIndex, 2'd0);
    compare("sat.firstValid", sFirstValid, 1'b1);
    compare("sat.ready",      sExpReady,   1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
